// File: rtl/pipeline_ctrl.sv
// Pipeline register sequencer for the 5-stage core: load enables, bubble flushes,
// data-memory wait/timeout tracking and saturating stall/flush statistics.
module pipeline_ctrl #(
  parameter int RW      = 5,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic [RW-1:0]    ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2,
    S_BAD      = 2'd3
  } state_t;

  state_t           r_state, w_next;
  logic [WW-1:0]    r_wait_cnt, w_wait_nxt;
  logic             r_timeout;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_mem_block, w_lu_hazard, w_active, w_freeze, w_stall, w_flush_ev;

  assign w_mem_block = mem_req & ~mem_ready;
  assign w_lu_hazard = ex_mem_read & (ex_rd != '0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign w_active    = (r_state == S_RUN) | (r_state == S_MEM_WAIT);
  assign w_freeze    = w_active & w_mem_block;
  // Branch flush outranks the load-use stall: the hazarding instruction is squashed anyway.
  assign w_flush_ev  = w_active & ~w_mem_block & ex_branch_taken;
  assign w_stall     = w_active & ~w_mem_block & ~ex_branch_taken & w_lu_hazard;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
      r_timeout  <= r_timeout | (w_next == S_ERR);
      if ((w_freeze | w_stall) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_ev && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_wait_nxt = '0;
    case (r_state)
      S_RUN: begin
        if (w_freeze) begin
          w_next     = S_MEM_WAIT;
          w_wait_nxt = WW'(1);
        end
      end
      S_MEM_WAIT: begin
        if (!w_freeze) begin
          w_next = S_RUN;
        end else if (r_wait_cnt == WW'(TIMEOUT)) begin
          w_next = S_ERR;
        end else begin
          w_wait_nxt = r_wait_cnt + WW'(1);
        end
      end
      S_ERR:   w_next = S_ERR;
      default: w_next = S_RUN;
    endcase
  end

  always_comb begin
    pc_load    = 1'b0;
    ifid_load  = 1'b0;
    idex_load  = 1'b0;
    exmem_load = 1'b0;
    memwb_load = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (rst || (r_state == S_ERR) || w_freeze) begin
      // everything held
    end else if (ex_branch_taken) begin
      {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = '1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_lu_hazard) begin
      idex_load  = 1'b1;
      exmem_load = 1'b1;
      memwb_load = 1'b1;
      idex_flush = 1'b1;
    end else begin
      {pc_load, ifid_load, idex_load, exmem_load, memwb_load} = '1;
    end
  end

  assign timeout   = r_timeout;
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the pipeline registers of the 5-stage RISC-V core. Each PC/IF-ID/ID-EX/EX-MEM/MEM-WB `register` instance takes its `load` from this block; flush outputs drive the `rst` of the IF/ID and ID/EX registers (OR-ed with global `rst`) to insert NOPs. The block resolves load-use stalls, taken-branch flushes and multi-cycle data-memory waits. It also detects memory timeouts and keeps saturating stall and flush statistics.

## Interface
Parameters:
- `RW`, 5, register-index width
- `TIMEOUT`, 15, max consecutive memory-wait cycles before error (≥1)
- `CNT_W`, 16, statistics counter width

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `id_rs1`, `id_rs2`  in  RW  source registers of instruction in ID
- `ex_rd`  in  RW  destination of instruction in EX
- `ex_mem_read`  in  1  instruction in EX is a load
- `ex_branch_taken`  in  1  branch/jump in EX resolved taken
- `mem_req`  in  1  MEM stage is accessing data memory this cycle
- `mem_ready`  in  1  data memory completes access this cycle
- `pc_load`, `ifid_load`, `idex_load`, `exmem_load`, `memwb_load`  out  1  register load enables
- `ifid_flush`, `idex_flush`  out  1  bubble insertion (clears the register at next edge)
- `timeout`  out  1  sticky memory-timeout error
- `state`  out  2  FSM state, debug
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating statistics

## Operation
- FSM states: RUN=0, MEM_WAIT=1, ERR=2. Encoding 3 is unreachable; if it is ever entered, the next state is RUN.
- `mem_block` = `mem_req & ~mem_ready`.
- `lu_hazard` = `ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2)`.
- Outputs are Mealy (combinational from state + inputs), evaluated in this priority order:
  1. `rst`=1: all loads 0, flushes 0.
  2. ERR: all loads 0, flushes 0.
  3. RUN or MEM_WAIT with `mem_block` (freeze): all loads 0, flushes 0. Branch and hazard inputs are ignored.
  4. `ex_branch_taken` (advance + flush): all loads 1, `ifid_flush`=1, `idex_flush`=1. This overrides `lu_hazard`.
  5. `lu_hazard` (load-use stall): `pc_load`=0, `ifid_load`=0, `idex_flush`=1, `idex_load`=1, `exmem_load`=1, `memwb_load`=1.
  6. Otherwise (normal advance): all loads 1, flushes 0.
- State transitions:
  - RUN → MEM_WAIT on freeze.
  - MEM_WAIT → RUN on any non-freeze cycle.
  - MEM_WAIT → ERR when a freeze cycle occurs with `wait_cnt` == TIMEOUT.
  - ERR → ERR until `rst`.
- `wait_cnt` (internal):
  - Set to 1 on RUN→MEM_WAIT.
  - Incremented on each further freeze cycle.
  - Cleared on any non-freeze cycle.
  - In total, TIMEOUT+1 consecutive freeze cycles lead to ERR.
- `timeout` is registered: set on entry to ERR, held until `rst`.
- `stall_cnt` increments by 1 on each freeze or load-use stall cycle. It saturates at 2^CNT_W−1.
- `flush_cnt` increments by 1 on each taken-branch flush cycle. It saturates at 2^CNT_W−1.
- Both counters count only in RUN or MEM_WAIT with `rst`=0.

## Timing
- Reset values, after the first edge with `rst`=1: `state`=RUN, `wait_cnt`=0, `timeout`=0, `stall_cnt`=0, `flush_cnt`=0.
- Combinational outputs in the cycle after reset: all loads 1, flushes 0, provided the inputs are idle.
- Combinational input-to-output path; zero-cycle latency from hazard/branch/`mem_ready` to the enables.
- State, counters and `timeout` update at the rising edge.
- A load-use stall lasts exactly one cycle. Next cycle the load is in MEM, so `lu_hazard` deasserts once upstream inputs update.
- `mem_ready` in the same cycle as `mem_req`: no freeze, zero wait cycles.
- `mem_ready` asserted while in MEM_WAIT: that cycle is an advance cycle, and the branch/hazard rules apply.
- `rst` mid-MEM_WAIT or in ERR: loads 0 that cycle; RUN and cleared counters from the next cycle.

## Test plan
- **Load-use stall.** `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5 → one cycle with `pc_load`=`ifid_load`=0, `idex_flush`=1, `exmem_load`=`memwb_load`=1; `stall_cnt` 0→1.
- **x0 destination.** `ex_rd`=0=`id_rs1`, `ex_mem_read`=1 → no stall; all loads 1; `stall_cnt` unchanged.
- **Branch over hazard.** `ex_branch_taken`=1 together with `lu_hazard` → all loads 1, both flushes 1; `flush_cnt`=1, `stall_cnt`=0.
- **Memory wait.** `mem_req`=1 with `mem_ready` low for 3 cycles, high on the 4th → loads 0 for 3 cycles, `state` 0→1→1→1→0, all loads 1 on the 4th cycle, `stall_cnt`=3.
- **Timeout and recovery.** `mem_req`=1, `mem_ready`=0 held with TIMEOUT=15 → ERR after 16 freeze cycles, `state`=2, `timeout`=1, loads stay 0 even when `mem_ready` rises. `rst` pulse → `state`=0, `timeout`=0, counters 0.
- **Saturation.** With CNT_W=4, apply 20 load-use stalls → `stall_cnt` holds at 15.
